// File: rtl/frame_diff_detect.sv
// Frame-difference motion detector: luma of live vs delayed pixel, thresholded, plus per-frame stats.
// Define MOTION_BOX_EN to compile in bounding-box tracking; otherwise the box outputs are tied to 0.
module frame_diff_detect #(
  parameter int unsigned IMG_HDISP = 32,
  parameter int unsigned IMG_VDISP = 32,
  parameter int unsigned CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [23:0]      per_img_Bit,
  input  logic [23:0]      dly_img_Bit,
  input  logic [7:0]       diff_thresh,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit,
  output logic [CNT_W-1:0] motion_cnt,
  output logic [10:0]      box_xmin,
  output logic [10:0]      box_xmax,
  output logic [10:0]      box_ymin,
  output logic [10:0]      box_ymax,
  output logic             box_valid,
  output logic             frame_done
);
  typedef enum logic [1:0] {StWait, StActive, StLatch} state_e;

  logic [3:0]  vs_sr_q, hr_sr_q, ce_sr_q, rise_sr_q;
  logic        vs_post_prev_q, armed_q;
  logic [7:0]  thr_q;
  logic        in_rise, post_rise, post_fall;
  logic [15:0] rc_q, gc_q, bc_q, rd_q, gd_q, bd_q;
  logic [7:0]  yc_q, yd_q, diff_q;
  logic        bit_q;

  // A rising edge only counts once vsync has been seen low since reset, so a frame
  // already in progress at reset release is discarded.
  assign in_rise   = per_frame_vsync & ~vs_sr_q[0] & armed_q;
  assign post_rise = rise_sr_q[3];
  assign post_fall = ~vs_sr_q[3] & vs_post_prev_q;

  assign post_frame_vsync = vs_sr_q[3];
  assign post_frame_href  = hr_sr_q[3];
  assign post_frame_clken = ce_sr_q[3];
  assign post_img_Bit     = bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr_q        <= '0;
      hr_sr_q        <= '0;
      ce_sr_q        <= '0;
      rise_sr_q      <= '0;
      vs_post_prev_q <= 1'b0;
      armed_q        <= 1'b0;
      thr_q          <= '0;
    end else begin
      vs_sr_q        <= {vs_sr_q[2:0], per_frame_vsync};
      hr_sr_q        <= {hr_sr_q[2:0], per_frame_href};
      ce_sr_q        <= {ce_sr_q[2:0], per_frame_clken};
      rise_sr_q      <= {rise_sr_q[2:0], in_rise};
      vs_post_prev_q <= vs_sr_q[3];
      armed_q        <= armed_q | ~per_frame_vsync;
      if (in_rise) thr_q <= diff_thresh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q   <= '0;
      gc_q   <= '0;
      bc_q   <= '0;
      rd_q   <= '0;
      gd_q   <= '0;
      bd_q   <= '0;
      yc_q   <= '0;
      yd_q   <= '0;
      diff_q <= '0;
      bit_q  <= 1'b0;
    end else begin
      rc_q   <= 16'(per_img_Bit[23:16]) * 16'd77;
      gc_q   <= 16'(per_img_Bit[15:8]) * 16'd150;
      bc_q   <= 16'(per_img_Bit[7:0]) * 16'd29;
      rd_q   <= 16'(dly_img_Bit[23:16]) * 16'd77;
      gd_q   <= 16'(dly_img_Bit[15:8]) * 16'd150;
      bd_q   <= 16'(dly_img_Bit[7:0]) * 16'd29;
      // Product sum peaks at 65280, so 16 bits cannot overflow.
      yc_q   <= 8'((rc_q + gc_q + bc_q) >> 8);
      yd_q   <= 8'((rd_q + gd_q + bd_q) >> 8);
      diff_q <= (yc_q >= yd_q) ? (yc_q - yd_q) : (yd_q - yc_q);
      bit_q  <= (diff_q > thr_q) & ce_sr_q[2];
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, motion_cnt_q, motion_cnt_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    motion_cnt_d = motion_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      StWait: begin
        if (post_rise) begin
          state_d = StActive;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (bit_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        if (post_fall) state_d = StLatch;
      end
      StLatch: begin
        motion_cnt_d = cnt_q;
        frame_done_d = 1'b1;
        state_d      = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWait;
      cnt_q        <= '0;
      motion_cnt_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      motion_cnt_q <= motion_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign motion_cnt = motion_cnt_q;
  assign frame_done = frame_done_q;

`ifdef MOTION_BOX_EN
  localparam logic [10:0] XLast = 11'(IMG_HDISP - 1);
  localparam logic [10:0] YLast = 11'(IMG_VDISP - 1);

  logic        hr_post_prev_q, href_fall, vs_rise_raw;
  logic [10:0] x_q, y_q;
  logic [10:0] xmin_q, xmax_q, ymin_q, ymax_q, xmin_d, xmax_d, ymin_d, ymax_d;
  logic [10:0] bxmin_q, bxmax_q, bymin_q, bymax_q, bxmin_d, bxmax_d, bymin_d, bymax_d;
  logic        bvalid_q, bvalid_d;

  assign href_fall   = ~hr_sr_q[3] & hr_post_prev_q;
  assign vs_rise_raw = vs_sr_q[3] & ~vs_post_prev_q;

  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (state_q == StWait && post_rise) begin
      xmin_d = XLast;
      ymin_d = YLast;
      xmax_d = '0;
      ymax_d = '0;
    end else if (state_q == StActive && bit_q) begin
      if (x_q < xmin_q) xmin_d = x_q;
      if (x_q > xmax_q) xmax_d = x_q;
      if (y_q < ymin_q) ymin_d = y_q;
      if (y_q > ymax_q) ymax_d = y_q;
    end
  end

  always_comb begin
    bxmin_d  = bxmin_q;
    bxmax_d  = bxmax_q;
    bymin_d  = bymin_q;
    bymax_d  = bymax_q;
    bvalid_d = bvalid_q;
    if (state_q == StLatch) begin
      if (cnt_q != '0) begin
        bxmin_d  = xmin_q;
        bxmax_d  = xmax_q;
        bymin_d  = ymin_q;
        bymax_d  = ymax_q;
        bvalid_d = 1'b1;
      end else begin
        bxmin_d  = '0;
        bxmax_d  = '0;
        bymin_d  = '0;
        bymax_d  = '0;
        bvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_post_prev_q <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      xmin_q         <= '0;
      xmax_q         <= '0;
      ymin_q         <= '0;
      ymax_q         <= '0;
      bxmin_q        <= '0;
      bxmax_q        <= '0;
      bymin_q        <= '0;
      bymax_q        <= '0;
      bvalid_q       <= 1'b0;
    end else begin
      hr_post_prev_q <= hr_sr_q[3];
      if (href_fall) x_q <= '0;
      else if (ce_sr_q[3] && x_q != XLast) x_q <= x_q + 11'd1;
      if (vs_rise_raw) y_q <= '0;
      else if (href_fall && y_q != YLast) y_q <= y_q + 11'd1;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      bxmin_q  <= bxmin_d;
      bxmax_q  <= bxmax_d;
      bymin_q  <= bymin_d;
      bymax_q  <= bymax_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign box_xmin  = bxmin_q;
  assign box_xmax  = bxmax_q;
  assign box_ymin  = bymin_q;
  assign box_ymax  = bymax_q;
  assign box_valid = bvalid_q;
`else
  assign box_xmin  = '0;
  assign box_xmax  = '0;
  assign box_ymin  = '0;
  assign box_ymax  = '0;
  assign box_valid = 1'b0;
`endif

endmodule

// File: tb/tb_frame_diff_detect.sv
// Bench for frame_diff_detect: frame-level vector table plus per-cycle scoreboard of post_* and stats.
module tb_frame_diff_detect;
  localparam int H  = 32;
  localparam int V  = 32;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          per_frame_vsync, per_frame_href, per_frame_clken;
  logic [23:0]   per_img_Bit, dly_img_Bit;
  logic [7:0]    diff_thresh;
  logic          post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
  logic [CW-1:0] motion_cnt;
  logic [10:0]   box_xmin, box_xmax, box_ymin, box_ymax;
  logic          box_valid, frame_done;

  always #5 clk = ~clk;

  frame_diff_detect #(.IMG_HDISP(H), .IMG_VDISP(V), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_Bit(per_img_Bit), .dly_img_Bit(dly_img_Bit),
    .diff_thresh(diff_thresh),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Bit(post_img_Bit),
    .motion_cnt(motion_cnt), .box_xmin(box_xmin), .box_xmax(box_xmax),
    .box_ymin(box_ymin), .box_ymax(box_ymax), .box_valid(box_valid), .frame_done(frame_done)
  );

  typedef struct {
    int kind; int thr; int thr_mid; int gap;
    int exp_cnt; int exp_valid; int xmin; int xmax; int ymin; int ymax;
  } vec_t;
  typedef struct {
    int done_cyc; int cnt; int valid; int xmin; int xmax; int ymin; int ymax;
  } frm_t;

  logic [3:0] sb[$];
  frm_t       fq[$];
  vec_t       vecs[8];
  int checks = 0, errors = 0, cyc = 0;

  logic m_prev_vs, m_prev_hr, m_armed, m_active;
  int m_thr, m_cnt, m_x, m_y, m_xmin, m_xmax, m_ymin, m_ymax;
  int last_cnt, last_valid, last_xmin, last_xmax, last_ymin, last_ymax;
  logic cur_vs, cur_hr, cur_ce;
  logic [23:0] cur_live, cur_dly;
  logic [7:0] cur_thr;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  function automatic int luma(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
  endfunction

  task automatic sample();
    logic [3:0] e;
    logic       due;
    frm_t       f;
    if (sb.size() == 4) begin
      e = sb.pop_front();
      check("post_sync_bit", {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit}, e);
    end
    due = (fq.size() > 0) && (fq[0].done_cyc == cyc);
    check("frame_done", frame_done, due);
    if (due) begin
      f = fq.pop_front();
      last_cnt  = f.cnt;  last_valid = f.valid;
      last_xmin = f.xmin; last_xmax  = f.xmax; last_ymin = f.ymin; last_ymax = f.ymax;
    end
    check("motion_cnt", motion_cnt, CW'(last_cnt));
    check("box", {box_valid, box_xmin, box_xmax, box_ymin, box_ymax},
          {last_valid[0], 11'(last_xmin), 11'(last_xmax), 11'(last_ymin), 11'(last_ymax)});
  endtask

  task automatic apply(input logic vs, input logic hr, input logic ce,
                       input logic [23:0] live, input logic [23:0] dly, input logic [7:0] thr);
    logic rise, bitv;
    int   yl, yd, d;
    frm_t f;
    per_frame_vsync = vs; per_frame_href = hr; per_frame_clken = ce;
    per_img_Bit = live; dly_img_Bit = dly; diff_thresh = thr;
    cur_vs = vs; cur_hr = hr; cur_ce = ce; cur_live = live; cur_dly = dly; cur_thr = thr;
    rise = vs && !m_prev_vs && m_armed;
    if (rise) m_thr = int'(thr);
    yl = luma(live);
    yd = luma(dly);
    d = (yl > yd) ? yl - yd : yd - yl;
    bitv = ce && (d > m_thr);
    sb.push_back({vs, hr, ce, bitv});
    if (m_active && bitv) begin
      m_cnt++;
      if (m_x < m_xmin) m_xmin = m_x;
      if (m_x > m_xmax) m_xmax = m_x;
      if (m_y < m_ymin) m_ymin = m_y;
      if (m_y > m_ymax) m_ymax = m_y;
    end
    if (rise) begin
      m_active = 1'b1; m_cnt = 0;
      m_xmin = H - 1; m_ymin = V - 1; m_xmax = 0; m_ymax = 0;
    end
    if (!hr && m_prev_hr) begin
      m_x = 0;
      if (m_y < V - 1) m_y++;
    end else if (ce && m_x < H - 1) m_x++;
    if (vs && !m_prev_vs) m_y = 0;
    if (!vs && m_prev_vs && m_active) begin
      f.done_cyc = cyc + 6;
      f.cnt = m_cnt;
`ifdef MOTION_BOX_EN
      f.valid = (m_cnt > 0) ? 1 : 0;
      f.xmin = (m_cnt > 0) ? m_xmin : 0; f.xmax = (m_cnt > 0) ? m_xmax : 0;
      f.ymin = (m_cnt > 0) ? m_ymin : 0; f.ymax = (m_cnt > 0) ? m_ymax : 0;
`else
      f.valid = 0; f.xmin = 0; f.xmax = 0; f.ymin = 0; f.ymax = 0;
`endif
      fq.push_back(f);
      m_active = 1'b0;
    end
    m_armed   = m_armed | !vs;
    m_prev_vs = vs;
    m_prev_hr = hr;
  endtask

  task automatic tick(input logic vs, input logic hr, input logic ce,
                      input logic [23:0] live, input logic [23:0] dly, input logic [7:0] thr);
    @(posedge clk);
    #1;
    cyc++;
    sample();
    apply(vs, hr, ce, live, dly, thr);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, motion_cnt,
                 box_xmin, box_xmax, box_ymin, box_ymax, box_valid, frame_done}, '0);
  endtask

  // Inputs are held at their current values across the reset window.
  task automatic reset_seq(input int n);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    sb.delete();
    fq.delete();
    last_cnt = 0; last_valid = 0; last_xmin = 0; last_xmax = 0; last_ymin = 0; last_ymax = 0;
    m_prev_vs = 1'b0; m_prev_hr = 1'b0; m_armed = 1'b0; m_active = 1'b0;
    m_thr = 0; m_x = 0; m_y = 0; m_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_all_zero("reset_hold");
    end
    rst_n = 1'b1;
    apply(cur_vs, cur_hr, cur_ce, cur_live, cur_dly, cur_thr);
  endtask

  task automatic pix(input int kind, input int x, input int y,
                     output logic [23:0] live, output logic [23:0] dly);
    case (kind)
      0: begin live = 24'h808080; dly = 24'h808080; end
      1: begin live = (x == 5 && y == 7) ? 24'hFFFFFF : 24'h000000; dly = 24'h000000; end
      2: begin live = 24'h969696; dly = 24'h323232; end
      3: begin
        live = {8'(224 + x), 8'(224 + y), 8'(224 + x)};
        dly  = {8'(y), 8'(x), 8'(y)};
      end
      default: begin live = 24'($urandom); dly = 24'($urandom); end
    endcase
  endtask

  task automatic send_line(input int kind, input int y, input int gap, input logic [7:0] thr);
    logic [23:0] live, dly;
    for (int x = 0; x < H; x++) begin
      if (gap != 0) tick(1'b1, 1'b1, 1'b0, 24'($urandom), 24'($urandom), thr);
      pix(kind, x, y, live, dly);
      tick(1'b1, 1'b1, 1'b1, live, dly, thr);
    end
    repeat (3) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, thr);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] thr;
    thr = 8'(v.thr);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, thr);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, thr);
    for (int y = 0; y < V; y++) begin
      if (y == V / 2 && v.thr_mid >= 0) thr = 8'(v.thr_mid);
      send_line(v.kind, y, v.gap, thr);
    end
    repeat (2) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, thr);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, thr);
  endtask

  initial begin
    //            kind thr mid gap cnt  val xmin xmax ymin ymax
    vecs[0] = '{0,   0,  -1, 0,  0,    0,  0,   0,   0,   0};
    vecs[1] = '{1,   100,-1, 0,  1,    1,  5,   5,   7,   7};
    vecs[2] = '{2,   100,-1, 0,  0,    0,  0,   0,   0,   0};
    vecs[3] = '{2,   99, 100,0,  1024, 1,  0,   31,  0,   31};
    vecs[4] = '{2,   100,-1, 1,  0,    0,  0,   0,   0,   0};
    vecs[5] = '{3,   100,-1, 1,  1024, 1,  0,   31,  0,   31};
    vecs[6] = '{4,   40, -1, 1,  -1,   0,  0,   0,   0,   0};
    vecs[7] = '{1,   100,-1, 1,  1,    1,  5,   5,   7,   7};

    rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_Bit = '0; dly_img_Bit = '0; diff_thresh = '0;
    cur_vs = 1'b0; cur_hr = 1'b0; cur_ce = 1'b0; cur_live = '0; cur_dly = '0; cur_thr = '0;
    #2;
    reset_seq(4);

    foreach (vecs[i]) begin
      run_frame(vecs[i]);
      if (vecs[i].exp_cnt >= 0) begin
        check($sformatf("tbl%0d_cnt", i), motion_cnt, CW'(vecs[i].exp_cnt));
`ifdef MOTION_BOX_EN
        check($sformatf("tbl%0d_box", i), {box_valid, box_xmin, box_xmax, box_ymin, box_ymax},
              {vecs[i].exp_valid[0], 11'(vecs[i].xmin), 11'(vecs[i].xmax),
               11'(vecs[i].ymin), 11'(vecs[i].ymax)});
`else
        check($sformatf("tbl%0d_box", i), {box_valid, box_xmin, box_xmax, box_ymin, box_ymax}, '0);
`endif
      end
    end

    // Reset mid-frame while vsync stays high: the remainder of that frame must not report.
    repeat (4) tick(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 8'd0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 8'd0);
    for (int y = 0; y < 10; y++) send_line(0, y, 0, 8'd0);
    reset_seq(3);
    for (int y = 10; y < V; y++) send_line(0, y, 0, 8'd0);
    repeat (2) tick(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 8'd0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 8'd0);
    check("post_reset_no_stats", {motion_cnt, box_valid}, '0);

    // First complete frame after the reset reports normally.
    run_frame(vecs[1]);
    check("post_reset_cnt", motion_cnt, CW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
